bram_dp: RTL
============

// Module: bram_dp
//
// PURPOSE
// Parametrised dual-port block RAM, successor to the single-port 16-bit main-memory BRAM.
// Port A is the CPU read/write port with byte-lane write enables. Port B is an
// independent read-only port for the video/DMA side.
// Adds configurable read latency, read-valid strobes, out-of-range detection and a
// post-reset clear sequencer that zeroes (or pre-fills) the array before first use.
//
// PARAMETERS
// DATA_W      16       word width in bits; must be a multiple of 8
// ADDR_W      16       address width of both ports
// DEPTH       61440    number of words (16'hF000); addresses >= DEPTH are out of range
// RD_LATENCY  1        read latency in cycles, 1 or 2 (2 adds an output register)
// WR_FIRST    0        port A read-during-write: 0 = return old word, 1 = return new merged word
// CLEAR_INIT  1        1 = run the clear sequencer after reset; 0 = skip it (busy stays 0)
// CLEAR_VAL   0        word written to every location by the clear sequencer
//
// PORTS
// clk         in   1          single clock; all logic is on its rising edge
// rst         in   1          synchronous, active-high reset
// a_addr      in   ADDR_W     port A word address
// a_cs_n      in   1          port A chip select, active low
// a_wr_n      in   1          port A write strobe, active low
// a_rd_n      in   1          port A read strobe, active low
// a_be        in   DATA_W/8   port A byte enables, active high; bit i gates bits [8i+7:8i]
// a_data_in   in   DATA_W     port A write data
// a_data_out  out  DATA_W     port A read data
// a_valid     out  1          1-cycle pulse: a_data_out carries the read result
// a_oor       out  1          1-cycle pulse, same timing as a_valid: the access was out of range
// b_addr      in   ADDR_W     port B word address
// b_rd_n      in   1          port B read strobe, active low
// b_data_out  out  DATA_W     port B read data
// b_valid     out  1          1-cycle pulse: b_data_out carries the read result
// busy        out  1          1 while the clear sequencer runs; all accesses are ignored
//
// BEHAVIOUR
// - Reset: a_data_out, b_data_out = 0; a_valid, a_oor, b_valid = 0; pipeline flushed.
//   If CLEAR_INIT=1: busy = 1 and the clear counter is set to 0.
// - Clear sequencer (states IDLE, CLEAR):
//   - CLEAR writes CLEAR_VAL to address cnt and then increments cnt, one word per cycle.
//   - After writing DEPTH-1 it moves to IDLE. busy falls in the cycle after that write,
//     so busy is high for exactly DEPTH cycles.
//   - rst asserted mid-clear restarts the sequencer at address 0.
//   - While busy, port A/B strobes are ignored: no write, no valid, no oor.
// - Port A write (cs_n=0, wr_n=0, addr<DEPTH): each byte lane with be[i]=1 is updated at
//   the clock edge. Lanes with be[i]=0 keep their value. a_be=0 writes nothing.
// - Port A read (cs_n=0, rd_n=0): data and a_valid appear RD_LATENCY cycles after the
//   strobe edge.
//   - Back-to-back reads are fully pipelined: one result per cycle.
//   - rd_n and wr_n both low to the same address: WR_FIRST selects old or merged-new data.
// - Port B read (rd_n=0): same latency and pipelining as port A.
//   - If port A writes the same address in the same cycle, port B returns the old word.
// - Out of range (addr >= DEPTH):
//   - Writes are dropped; the array is unchanged.
//   - Reads return 0 with the valid pulse.
//   - Port A out-of-range reads and writes raise a_oor at read-result timing.
// - a_cs_n=1 masks both a_wr_n and a_rd_n. Port B has no chip select.
// - Data outputs hold their last value between reads. Valid strobes are single-cycle per read.
// - rst mid-read: in-flight results are discarded and no valid pulse is emitted.
//
// TESTING
// 1. Reset with CLEAR_INIT=1, DEPTH=16: busy high for exactly 16 cycles; then read all
//    16 addresses on both ports -> all CLEAR_VAL.
// 2. Write 16'hA5A5 to addr 3, then write 16'hFF00 with a_be=2'b10 -> read addr 3 returns
//    16'hFFA5, a_valid exactly RD_LATENCY cycles after the strobe (test RD_LATENCY=1 and 2).
// 3. Port A writes 16'h1234 to addr 5 (old value 16'h0000) while port B reads addr 5 in the
//    same cycle -> b_data_out = 16'h0000; next-cycle port B read -> 16'h1234.
// 4. Same-cycle rd/wr on port A, addr 7: old 16'h1111, write 16'h2222 -> returns 16'h1111
//    (WR_FIRST=0) or 16'h2222 (WR_FIRST=1).
// 5. Port A write to addr DEPTH -> a_oor pulse and no array change; read addr DEPTH ->
//    data 0 with a_valid and a_oor both high.
// 6. Assert rst at clear count 8, then attempt a write during busy -> write ignored;
//    sequencer restarts at 0; busy high for DEPTH cycles after rst is released.

Source files
------------

// File: rtl/bram_dp.sv
// Dual-port block RAM: port A is read/write with byte lanes, port B is read-only.
// Includes a read pipeline (1 or 2 cycles), out-of-range flagging and a post-reset clear sequencer.
module bram_dp #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DEPTH      = 61440,
  parameter int unsigned       RD_LATENCY = 1,
  parameter bit                WR_FIRST   = 1'b0,
  parameter bit                CLEAR_INIT = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic                  a_cs_n,
  input  logic                  a_wr_n,
  input  logic                  a_rd_n,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [DATA_W-1:0]     a_data_in,
  output logic [DATA_W-1:0]     a_data_out,
  output logic                  a_valid,
  output logic                  a_oor,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic                  b_rd_n,
  output logic [DATA_W-1:0]     b_data_out,
  output logic                  b_valid,
  output logic                  busy
);

  localparam int unsigned       NB       = DATA_W / 8;
  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              clr_we;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              a_in_range, b_in_range;
  logic [IDX_W-1:0]  a_idx, b_idx;
  logic              a_wr_s, a_rd, a_we, a_oor_ev, b_rd;
  logic [DATA_W-1:0] a_merged, a_rdata, b_rdata;

  logic              a_v1_q, a_oor1_q, b_v1_q;
  logic [DATA_W-1:0] a_d1_q, b_d1_q;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_INIT ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q == CLEAR);

  // ---------------- access decode ----------------
  assign a_in_range = {1'b0, a_addr} < DEPTH_C;
  assign b_in_range = {1'b0, b_addr} < DEPTH_C;
  assign a_idx      = a_addr[IDX_W-1:0];
  assign b_idx      = b_addr[IDX_W-1:0];

  assign a_wr_s   = !busy && !a_cs_n && !a_wr_n;
  assign a_rd     = !busy && !a_cs_n && !a_rd_n;
  assign a_we     = a_wr_s && a_in_range && !rst;
  assign a_oor_ev = (a_rd || a_wr_s) && !a_in_range;
  assign b_rd     = !busy && !b_rd_n;

  always_comb begin
    a_merged = mem_q[a_idx];
    for (int unsigned i = 0; i < NB; i++) begin
      if (a_be[i]) a_merged[8*i +: 8] = a_data_in[8*i +: 8];
    end
  end

  // Read-during-write on A: the merged word is what the array will hold after this edge.
  always_comb begin
    a_rdata = '0;
    if (a_in_range) a_rdata = (WR_FIRST && a_we) ? a_merged : mem_q[a_idx];
  end

  always_comb begin
    b_rdata = '0;
    if (b_in_range) b_rdata = mem_q[b_idx];
  end

  // ---------------- storage array ----------------
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[cnt_q] <= CLEAR_VAL;
    end else if (a_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (a_be[i]) mem_q[a_idx][8*i +: 8] <= a_data_in[8*i +: 8];
      end
    end
  end

  // ---------------- read pipeline ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_v1_q   <= 1'b0;
      a_oor1_q <= 1'b0;
      a_d1_q   <= '0;
      b_v1_q   <= 1'b0;
      b_d1_q   <= '0;
    end else begin
      a_v1_q   <= a_rd;
      a_oor1_q <= a_oor_ev;
      b_v1_q   <= b_rd;
      if (a_rd) a_d1_q <= a_rdata;
      if (b_rd) b_d1_q <= b_rdata;
    end
  end

  if (RD_LATENCY >= 2) begin : g_lat2
    logic              a_v2_q, a_oor2_q, b_v2_q;
    logic [DATA_W-1:0] a_d2_q, b_d2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        a_v2_q   <= 1'b0;
        a_oor2_q <= 1'b0;
        a_d2_q   <= '0;
        b_v2_q   <= 1'b0;
        b_d2_q   <= '0;
      end else begin
        a_v2_q   <= a_v1_q;
        a_oor2_q <= a_oor1_q;
        b_v2_q   <= b_v1_q;
        if (a_v1_q) a_d2_q <= a_d1_q;
        if (b_v1_q) b_d2_q <= b_d1_q;
      end
    end

    assign a_valid    = a_v2_q;
    assign a_oor      = a_oor2_q;
    assign a_data_out = a_d2_q;
    assign b_valid    = b_v2_q;
    assign b_data_out = b_d2_q;
  end else begin : g_lat1
    assign a_valid    = a_v1_q;
    assign a_oor      = a_oor1_q;
    assign a_data_out = a_d1_q;
    assign b_valid    = b_v1_q;
    assign b_data_out = b_d1_q;
  end

endmodule
